// File: rtl/fnd_pkg.sv
// Shared widths, limits, conversion state encoding and double-dabble helpers
// for the FND display source path.
package fnd_pkg;

    localparam int unsigned BIN_W      = 14;
    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 2;
    localparam int unsigned BCD_W      = BCD_DIGITS * 4;
    localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Values above four decimal digits are clamped to 9999.
    function automatic logic [BIN_W-1:0] sat_bin(input logic [BIN_W-1:0] b);
        return (b > MAX_VAL) ? MAX_VAL : b;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, 14 shifts per
// conversion, with a single-cycle done pulse once the BCD result is final.
module bin_to_bcd_seq
    import fnd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [13:0]      bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    conv_state_t              r_state;
    logic [BCD_W+BIN_W-1:0]   r_shift;
    logic [3:0]               r_iter;
    logic [BCD_W+BIN_W-1:0]   w_adj;

    assign w_adj = {dabble_adjust(r_shift[BCD_W+BIN_W-1:BIN_W]), r_shift[BIN_W-1:0]};
    assign bcd   = r_shift[BCD_W+BIN_W-1:BIN_W];

    // A start in DONE is honoured so back-to-back conversions lose no cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_iter  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_shift <= {BCD_W'(0), sat_bin(bin)};
                        r_iter  <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_shift <= {w_adj[BCD_W+BIN_W-2:0], 1'b0};
                    r_iter  <= r_iter + 1'b1;
                    if (r_iter == 4'(BIN_W - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND source: converts a binary value to BCD on request and scans the
// last completed value one digit per refresh slot, with optional zero blanking.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_Start,
    input  logic [13:0] i_Bin,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Overflow,
    output logic        o_En,
    output logic [1:0]  o_DigitSelect,
    output logic [3:0]  o_Value
);

    localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic                   w_busy;
    logic                   w_done;
    logic [BCD_W-1:0]       w_bcd;
    logic [BCD_DIGITS-1:0]  w_blank_vec;
    logic [3:0]             w_nib;

    logic [PRESC_W-1:0]     r_presc;
    logic [DIGIT_W-1:0]     r_idx;
    logic [BCD_W-1:0]       r_disp;
    logic                   r_valid;
    logic                   r_overflow;
    logic                   r_en;
    logic [DIGIT_W-1:0]     r_sel;
    logic [3:0]             r_value;

    bin_to_bcd_seq u_conv (
        .clk   (i_clk),
        .reset (i_reset),
        .start (i_Start),
        .bin   (i_Bin),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // Digit k>0 is blank when it and every digit above it are zero.
    always_comb begin
        w_blank_vec = '0;
        for (int k = 1; k < int'(BCD_DIGITS); k++) begin
            w_blank_vec[k] = BLANK_LZ && ((r_disp >> (4 * k)) == '0);
        end
    end

    assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_disp     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_en       <= 1'b0;
            r_sel      <= '0;
            r_value    <= '0;
        end else begin
            if (r_presc == PRESC_W'(SCAN_DIV - 1)) begin
                r_presc <= '0;
                r_idx   <= r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (i_Start && !w_busy) begin
                r_overflow <= (i_Bin > MAX_VAL);
            end

            // Display only changes on a finished conversion, so no tearing.
            if (w_done) begin
                r_disp  <= w_bcd;
                r_valid <= 1'b1;
            end

            r_sel   <= r_idx;
            r_value <= w_blank_vec[r_idx] ? 4'd0 : w_nib;
            r_en    <= r_valid && !w_blank_vec[r_idx];
        end
    end

    assign o_Busy        = w_busy;
    assign o_Done        = w_done;
    assign o_Overflow    = r_overflow;
    assign o_En          = r_en;
    assign o_DigitSelect = r_sel;
    assign o_Value       = r_value;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed plus random bench for fnd_scan_controller, checked cycle by cycle
// against a decimal-arithmetic model of conversion timing, display and scan.
module tb_fnd_scan_controller;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin;

    logic       a_busy, a_done, a_ovf, a_en;
    logic [1:0] a_sel;
    logic [3:0] a_val;
    logic       b_busy, b_done, b_ovf, b_en;
    logic [1:0] b_sel;
    logic [3:0] b_val;

    int total = 0;
    int bad   = 0;

    // Model state
    int n;        // edges since reset
    int m_k;      // cycles since accepted start (0 = none in flight)
    int m_conv;   // saturated value of the conversion in flight
    int m_ovf;
    int m_disp;
    int m_valid;

    always #5 clk = ~clk;

    fnd_scan_controller #(.SCAN_DIV(D), .BLANK_LZ(1'b1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_Start(start), .i_Bin(bin),
        .o_Busy(a_busy), .o_Done(a_done), .o_Overflow(a_ovf),
        .o_En(a_en), .o_DigitSelect(a_sel), .o_Value(a_val)
    );

    fnd_scan_controller #(.SCAN_DIV(D), .BLANK_LZ(1'b0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_Start(start), .i_Bin(bin),
        .o_Busy(b_busy), .o_Done(b_done), .o_Overflow(b_ovf),
        .o_En(b_en), .o_DigitSelect(b_sel), .o_Value(b_val)
    );

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic int digit(input int v, input int k);
        return (v / pow10(k)) % 10;
    endfunction

    function automatic int blanked(input int v, input int k, input int blz);
        return (blz != 0 && k > 0 && v < pow10(k)) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    // Advance one clock, updating the model, then compare every output.
    task automatic step();
        int sel, ev1, ee1, ev0, ee0, acc, busy_now;
        if (rst) begin
            n = 0; m_k = 0; m_conv = 0; m_ovf = 0; m_disp = 0; m_valid = 0;
            sel = 0; ev1 = 0; ee1 = 0; ev0 = 0; ee0 = 0;
        end else begin
            sel = (n / D) % 4;
            ev1 = blanked(m_disp, sel, 1) ? 0 : digit(m_disp, sel);
            ee1 = (m_valid != 0 && blanked(m_disp, sel, 1) == 0) ? 1 : 0;
            ev0 = digit(m_disp, sel);
            ee0 = m_valid;
            if (m_k == 15) begin
                m_disp  = m_conv;
                m_valid = 1;
            end
            busy_now = (m_k >= 1 && m_k <= 14) ? 1 : 0;
            acc = (start && busy_now == 0) ? 1 : 0;
            if (acc != 0) begin
                m_conv = (int'(bin) > 9999) ? 9999 : int'(bin);
                m_ovf  = (int'(bin) > 9999) ? 1 : 0;
                m_k    = 1;
            end else if (busy_now != 0) begin
                m_k = m_k + 1;
            end else begin
                m_k = 0;
            end
            n++;
        end
        @(posedge clk);
        #1;
        check("busy",  32'(a_busy), (m_k >= 1 && m_k <= 14) ? 32'd1 : 32'd0);
        check("done",  32'(a_done), (m_k == 15) ? 32'd1 : 32'd0);
        check("ovf",   32'(a_ovf),  32'(m_ovf));
        check("sel",   32'(a_sel),  32'(sel));
        check("value", 32'(a_val),  32'(ev1));
        check("en",    32'(a_en),   32'(ee1));
        check("nb_sel",   32'(b_sel), 32'(sel));
        check("nb_value", 32'(b_val), 32'(ev0));
        check("nb_en",    32'(b_en),  32'(ee0));
    endtask

    task automatic idle(input int cycles);
        start = 1'b0;
        repeat (cycles) step();
    endtask

    task automatic pulse(input int v);
        start = 1'b1;
        bin   = 14'(v);
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bin = '0;
        step();
        step();
        rst = 1'b0;

        idle(20);

        pulse(1234);   idle(40);
        pulse(10000);  idle(40);
        pulse(42);     idle(40);
        pulse(0);      idle(40);

        // Start while busy is dropped
        pulse(1234);   idle(4);
        pulse(42);     idle(40);

        // Reset in the middle of a conversion
        pulse(5678);   idle(40);
        pulse(1234);   idle(6);
        rst = 1'b1;    step();
        rst = 1'b0;    idle(30);

        // Start held high: restarts land in the done cycle
        repeat (50) begin
            start = 1'b1;
            bin   = 14'($urandom_range(0, 16383));
            step();
        end
        idle(20);

        repeat (500) begin
            start = ($urandom_range(0, 14) == 0);
            bin   = 14'($urandom_range(0, 16383));
            rst   = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
- Source side of the 4-digit FND display path. Drives the digit-select, BCD-value and enable inputs of the existing BCD-to-FND decoder.
- Accepts a 14-bit binary number on a start strobe and converts it to 4 BCD digits with a sequential double-dabble engine.
- Free-running time-multiplexed scan presents one digit per refresh slot.
- Display holds the last completed value; a new value appears only when a conversion finishes, so there is no tearing.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); minimum 2; benches use 4.
- BLANK_LZ, 1, 1 = suppress leading zeros by dropping o_En on digits above the most significant nonzero digit (digit 0 always enabled).

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_Start  input  1  single-cycle request to convert i_Bin; honoured only when the block is not busy.
- i_Bin  input  14  unsigned binary value to display.
- o_Busy  output  1  conversion in progress.
- o_Done  output  1  one-cycle pulse when a new value is latched into the display register.
- o_Overflow  output  1  last accepted i_Bin exceeded 9999 and was saturated.
- o_En  output  1  enable for the current digit.
- o_DigitSelect  output  2  current digit index, 0 = ones.
- o_Value  output  4  BCD nibble for the current digit.

Behaviour:
- Reset values:
  - o_Busy=0, o_Done=0, o_Overflow=0, o_En=0, o_DigitSelect=0, o_Value=0.
  - Display register = 0000, prescaler = 0, digit index = 0.
  - Display is blank until the first completed conversion (display-valid flag = 0).
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: when i_Start=1 (cycle 0), capture min(i_Bin, 9999) and set o_Overflow = (i_Bin > 9999). Go to SHIFT.
  - SHIFT: runs 14 cycles (cycles 1..14), o_Busy=1. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. The iteration counter is 4 bits.
  - DONE (cycle 15): o_Busy=0, o_Done=1. Display register <= BCD result, display-valid <= 1. Return to IDLE.
  - i_Start in cycle 15 is accepted, so back-to-back conversions are 15 cycles apart.
  - i_Start while o_Busy=1 is ignored, with no queuing.
  - o_Overflow holds until the next accepted start.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously from reset, independent of the FSM.
  - At terminal count the digit index increments 0->1->2->3->0 (wraps at 3).
- Scan outputs (registered, updated the cycle after an index change):
  - o_DigitSelect = index.
  - o_Value = display nibble for index.
  - o_En = display-valid AND (not blanked).
- Blanking when BLANK_LZ=1: digit k is blanked if all display digits with index >= k are 0, with k>0. Blanked digits drive o_Value=0. Value 0 shows digit 0 only.
- Display update mid-slot: the new nibble appears on the next registered output cycle. The scan position is not reset.
- Reset mid-operation returns every register to its reset value on the next edge. Any conversion in progress is discarded.

Decomposition:
- Package fnd_pkg:
  - BIN_W=14, BCD_DIGITS=4, DIGIT_W=2, MAX_VAL=14'd9999.
  - Conversion state enum {IDLE, SHIFT, DONE}.
- Sub-module bin_to_bcd_seq holds the double-dabble FSM with ports clk/reset/start/bin/busy/done/bcd[15:0].
- Scan counter, blanking logic and output registers stay in the top module.

Test Plan:
- Reset, then run 20 cycles with no start (SCAN_DIV=4) -> o_En=0 throughout, o_DigitSelect steps 0,1,2,3 every 4 cycles, o_Value=0, o_Busy=0, o_Done=0.
- i_Bin=1234, start at cycle 0 -> o_Busy=1 in cycles 1..14, o_Done=1 in cycle 15 only. Scan then shows digit0=4, 1=3, 2=2, 3=1, all with o_En=1.
- i_Bin=10000 -> displays 9999 and o_Overflow=1. A following start with i_Bin=42 -> o_Overflow=0; digits 2 and 3 blanked (o_En=0, o_Value=0), digit1=4, digit0=2.
- i_Bin=0 with BLANK_LZ=1 -> only digit 0 enabled, value 0. Same stimulus with BLANK_LZ=0 -> all four digits enabled, showing 0.
- Convert 1234, pulse i_Start with i_Bin=42 at cycle 5 -> ignored; display 1234, exactly one o_Done pulse.
- Start 1234 after a prior 5678 is displayed, assert i_reset at cycle 7 -> next cycle o_Busy=0, o_En=0, o_DigitSelect=0, display 0000, and no o_Done is produced.
